// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH   = 64;
  // Accept edge to done: WIDTH iteration cycles plus the final count check.
  localparam int DIV_LATENCY = DIV_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor if that does not go negative.
module div_iter_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Two's-complement subtract (inverted divisor, carry-in 1); bit WIDTH is the borrow.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted + {1'b1, ~divisor_i} + {{WIDTH{1'b0}}, 1'b1};
    q_o     = ~diff[WIDTH];
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider: one restoring iteration per clock, MSB first.
// The dividend register doubles as the quotient register: dividend bits
// shift out of the top while quotient bits shift in at the bottom.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // State, counter and datapath registers; reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state, iteration control and status outputs.
  // A zero divisor passes through RUN for one cycle without iterating so that
  // done appears on the edge after acceptance, with results already loaded.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          dvs_d   = divisor;
          if (divisor == '0) begin
            dbz_d = 1'b1;
            quo_d = '1;
            rem_d = dividend;
          end else begin
            dbz_d = 1'b0;
            quo_d = dividend;
            rem_d = '0;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (dbz_q || (cnt_q == CNT_LAST)) begin
          state_d = DONE;
        end else begin
          quo_d = {quo_q[WIDTH-2:0], step_q};
          rem_d = step_rem;
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH = 64).
module tb_seq_divider;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs [9];

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present start for exactly one rising edge (the accept edge).
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Edges after the accept edge until done is seen; -1 if the bound expires.
  task automatic wait_done(input int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    launch(v.a, v.b);
    wait_done(200, lat);
    chk("latency", W'(lat), W'(v.lat));
    chk("quotient", quotient, v.q);
    chk("remainder", remainder, v.r);
    chk("div_by_zero", W'(div_by_zero), W'(v.z));
    @(negedge clk);
    chk("done_one_cycle", W'(done), '0);
    chk("idle_after_done", W'(busy), '0);
    @(negedge clk);
    @(negedge clk);
    chk("quotient_held", quotient, v.q);
    chk("remainder_held", remainder, v.r);
    chk("dbz_held", W'(div_by_zero), W'(v.z));
  endtask

  initial begin
    int first_done;
    int ndone;
    int busy_lo;

    vecs[0] = '{a: 64'd100, b: 64'd7, q: 64'd14, r: 64'd2, z: 1'b0, lat: 65};
    vecs[1] = '{a: 64'd5, b: 64'd9, q: 64'd0, r: 64'd5, z: 1'b0, lat: 65};
    vecs[2] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1,
                q: 64'hFFFF_FFFF_FFFF_FFFF, r: 64'd0, z: 1'b0, lat: 65};
    vecs[3] = '{a: 64'h8000_0000_0000_0000, b: 64'hFFFF_FFFF_FFFF_FFFF,
                q: 64'd0, r: 64'h8000_0000_0000_0000, z: 1'b0, lat: 65};
    vecs[4] = '{a: 64'd42, b: 64'd0, q: 64'hFFFF_FFFF_FFFF_FFFF, r: 64'd42, z: 1'b1, lat: 1};
    vecs[5] = '{a: 64'd12345, b: 64'd100, q: 64'd123, r: 64'd45, z: 1'b0, lat: 65};
    vecs[6] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'h1_0000_0000,
                q: 64'hFFFF_FFFF, r: 64'hFFFF_FFFF, z: 1'b0, lat: 65};
    vecs[7] = '{a: 64'd0, b: 64'd5, q: 64'd0, r: 64'd0, z: 1'b0, lat: 65};
    vecs[8] = '{a: 64'd81, b: 64'd9, q: 64'd9, r: 64'd0, z: 1'b0, lat: 65};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_quotient", quotient, '0);
    chk("reset_remainder", remainder, '0);
    chk("reset_dbz", W'(div_by_zero), '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
    end

    // start held high through the run, operands changed mid-run
    @(negedge clk);
    start    = 1'b1;
    dividend = 64'd100;
    divisor  = 64'd7;
    @(negedge clk);
    first_done = -1;
    ndone      = 0;
    busy_lo    = 0;
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      if (k == 30) begin
        dividend = 64'd9;
        divisor  = 64'd3;
      end
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end else if (!busy) begin
        busy_lo++;
      end
    end
    start = 1'b0;
    chk("held_done_count", W'(ndone), W'(1));
    chk("held_done_latency", W'(first_done), W'(65));
    chk("held_busy_gaps", W'(busy_lo), '0);
    chk("held_quotient", quotient, 64'd14);
    chk("held_remainder", remainder, 64'd2);
    @(negedge clk);
    chk("held_no_restart_busy", W'(busy), '0);
    chk("held_no_restart_done", W'(done), '0);
    @(negedge clk);
    chk("held_still_idle", W'(busy), '0);

    // reset asserted 30 cycles into a run
    launch(64'd100, 64'd7);
    for (int k = 1; k <= 30; k++) @(negedge clk);
    chk("midrun_busy_before", W'(busy), W'(1));
    reset = 1'b1;
    #1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_quotient", quotient, '0);
    chk("abort_remainder", remainder, '0);
    chk("abort_dbz", W'(div_by_zero), '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", W'(ndone), '0);
    chk("abort_idle", W'(busy), '0);
    run_vec(vecs[8]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
